// File: rtl/fetch_buffer_pkg.sv
// Shared IFU configuration for the fetch buffer: NOP encoding and the
// fetch-buffer enable/depth configuration fields.
package fetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       fetch_buffer_en;
    logic [3:0] fetch_buffer_depth;
  } ifu_cfg_t;

  localparam ifu_cfg_t IFU_CFG = '{fetch_buffer_en: 1'b1, fetch_buffer_depth: 4'd3};

endpackage

// File: rtl/fetch_buffer_ptr.sv
// Modulo-DEPTH wrap counter with enable and synchronous clear; used for the
// fetch buffer's head and tail pointers.
module fetch_buffer_ptr #(
  parameter int DEPTH = 3,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and decode.
// Optional same-cycle empty-buffer bypass enabled by defining FETCHBUF_BYPASS_EN.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = int'(IFU_CFG.fetch_buffer_depth)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       FlushD,
  input  logic                       StallD,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic                       InstrValidF,
  output logic                       FetchStallF,
  output logic [WIDTH-1:0]           InstrD,
  output logic                       InstrValidD,
  output logic [$clog2(DEPTH+1)-1:0] CountF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [WIDTH-1:0] storage [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             bypass_take;
  logic             push;
  logic             pop;

  assign empty       = (CountF == '0);
  assign full        = (CountF == CW'(DEPTH));
  assign FetchStallF = full;

`ifdef FETCHBUF_BYPASS_EN
  assign bypass = empty & InstrValidF & ~FlushD;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction that decode takes immediately never enters storage.
  assign bypass_take = bypass & ~StallD;
  assign push        = InstrValidF & ~full & ~FlushD & ~bypass_take;
  assign pop         = ~empty & ~StallD & ~FlushD;

  always_comb begin
    // NOTE: outputs get defaults first so no path through this block can
    // leave them unassigned and infer a latch.
    InstrValidD = ~empty | bypass;
    InstrD      = storage[head];
    if (empty) begin
      InstrD = bypass ? InstrF : WIDTH'(NOP_INSTR);
    end
  end

  fetch_buffer_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (FlushD),
    .en    (pop),
    .ptr   (head)
  );

  fetch_buffer_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clear (FlushD),
    .en    (push),
    .ptr   (tail)
  );

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      CountF <= '0;
    end else begin
      case ({push, pop})
        2'b10:   CountF <= CountF + CW'(1);
        2'b01:   CountF <= CountF - CW'(1);
        default: CountF <= CountF;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = push && (tail == PTR_W'(i));
    end
  end

  // NOTE: storage has no reset; an entry is only read after CountF says it
  // was written, so its power-up value never reaches decode.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        storage[i] <= InstrF;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer against a queue-based reference model;
// follows FETCHBUF_BYPASS_EN when the bench is built with it.
module tb_fetch_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = 1 + CW + 1 + WIDTH;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCHBUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             FlushD;
  logic             StallD;
  logic [WIDTH-1:0] InstrF;
  logic             InstrValidF;
  logic             FetchStallF;
  logic [WIDTH-1:0] InstrD;
  logic             InstrValidD;
  logic [CW-1:0]    CountF;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q [$];

  fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .FlushD      (FlushD),
    .StallD      (StallD),
    .InstrF      (InstrF),
    .InstrValidF (InstrValidF),
    .FetchStallF (FetchStallF),
    .InstrD      (InstrD),
    .InstrValidD (InstrValidD),
    .CountF      (CountF)
  );

  always #5 clk = ~clk;

  wire [OW-1:0] obs = {FetchStallF, CountF, InstrValidD, InstrD};

  // Expected {FetchStallF, CountF, InstrValidD, InstrD} for the current
  // model contents and current inputs.
  function automatic logic [OW-1:0] model_exp();
    logic [WIDTH-1:0] d;
    logic             v;
    if (q.size() > 0) begin
      d = q[0];
      v = 1'b1;
    end else if (BYPASS && InstrValidF && !FlushD) begin
      d = InstrF;
      v = 1'b1;
    end else begin
      d = NOP;
      v = 1'b0;
    end
    return {q.size() == DEPTH, CW'(q.size()), v, d};
  endfunction

  function automatic bit model_accepts();
    return !reset && !FlushD && InstrValidF && q.size() < DEPTH &&
           !(BYPASS && q.size() == 0 && !StallD);
  endfunction

  task automatic drive(input logic f, input logic s, input logic v, input logic [WIDTH-1:0] w);
    FlushD      = f;
    StallD      = s;
    InstrValidF = v;
    InstrF      = w;
    #1;
  endtask

  // Clock edge: update the model from the inputs held across the edge.
  task automatic advance();
    bit do_pop;
    bit do_push;
    @(posedge clk);
    if (reset || FlushD) begin
      q.delete();
    end else begin
      do_push = model_accepts();
      do_pop  = q.size() > 0 && !StallD;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(InstrF);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    advance();
    advance();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (obs !== {1'b0, CW'(0), 1'b0, NOP}) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, {1'b0, CW'(0), 1'b0, NOP});
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (obs !== model_exp()) begin
      n_fail++;
      $display("FAIL reset_idle2: got %h expected %h", obs, model_exp());
    end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b0, 1'b1, 32'h00A0_0093);
    n_checks++;
    if (obs !== model_exp()) begin
      n_fail++;
      $display("FAIL single_push: got %h expected %h", obs, model_exp());
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, '0);
`ifndef FETCHBUF_BYPASS_EN
    n_checks++;
    if (InstrD !== 32'h00A0_0093 || InstrValidD !== 1'b1) begin
      n_fail++;
      $display("FAIL single_visible: got %h/%b expected 00a00093/1", InstrD, InstrValidD);
    end
`endif
    n_checks++;
    if (obs !== model_exp()) begin
      n_fail++;
      $display("FAIL single_next: got %h expected %h", obs, model_exp());
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (CountF !== CW'(0) || InstrValidD !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained: count %0d valid %b expected 0/0", CountF, InstrValidD);
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] w [4];
    int idx = 0;
    int budget;
    w[0] = 32'h0010_0113; w[1] = 32'h0020_0193; w[2] = 32'h0030_0213; w[3] = 32'h0040_0293;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b1, w[idx]);
      n_checks++;
      if (obs !== model_exp()) begin
        n_fail++;
        $display("FAIL full_fill cycle %0d: got %h expected %h", c, obs, model_exp());
      end
      if (model_accepts()) idx++;
      advance();
    end
    drive(1'b0, 1'b1, 1'b1, w[idx]);
    n_checks++;
    if (FetchStallF !== 1'b1 || CountF !== CW'(3) || InstrD !== w[0]) begin
      n_fail++;
      $display("FAIL full_state: stall %b count %0d head %h expected 1/3/%h",
               FetchStallF, CountF, InstrD, w[0]);
    end
    budget = 0;
    while ((idx < 4 || q.size() > 0) && budget < 12) begin
      drive(1'b0, 1'b0, idx < 4, w[idx < 4 ? idx : 0]);
      n_checks++;
      if (obs !== model_exp()) begin
        n_fail++;
        $display("FAIL full_drain cycle %0d: got %h expected %h", budget, obs, model_exp());
      end
      if (model_accepts()) idx++;
      advance();
      budget++;
    end
    n_checks++;
    if (budget >= 12 || CountF !== CW'(0)) begin
      n_fail++;
      $display("FAIL full_drain_done: count %0d after %0d cycles expected 0", CountF, budget);
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h1000_0000 + 32'(c));
      n_checks++;
      if (obs !== model_exp()) begin
        n_fail++;
        $display("FAIL wrap cycle %0d: got %h expected %h", c, obs, model_exp());
      end
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (obs !== model_exp()) begin
        n_fail++;
        $display("FAIL wrap_drain %0d: got %h expected %h", c, obs, model_exp());
      end
      advance();
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0111);
    advance();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0222);
    advance();
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    n_checks++;
    if (obs !== model_exp()) begin
      n_fail++;
      $display("FAIL flush_pre: got %h expected %h", obs, model_exp());
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (CountF !== CW'(0) || InstrValidD !== 1'b0 || InstrD === 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL flush_post %0d: count %0d valid %b instr %h expected 0/0/%h",
                 c, CountF, InstrValidD, InstrD, NOP);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_fill();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0333);
    advance();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0444);
    advance();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0555);
    advance();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (obs !== {1'b0, CW'(0), 1'b0, NOP}) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got %h expected %h", obs, {1'b0, CW'(0), 1'b0, NOP});
    end
  endtask

`ifdef FETCHBUF_BYPASS_EN
  task automatic test_bypass();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0513);
    n_checks++;
    if (InstrD !== 32'h0000_0513 || InstrValidD !== 1'b1 || CountF !== CW'(0)) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h/%b/%0d expected 00000513/1/0",
               InstrD, InstrValidD, CountF);
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (CountF !== CW'(0) || InstrValidD !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_not_stored: count %0d valid %b expected 0/0", CountF, InstrValidD);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0, $urandom);
      n_checks++;
      if (obs !== model_exp()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", c, obs, model_exp());
      end
      advance();
    end
  endtask

  initial begin
    reset       = 1'b1;
    FlushD      = 1'b0;
    StallD      = 1'b0;
    InstrValidF = 1'b0;
    InstrF      = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid_fill();
`ifdef FETCHBUF_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Circular instruction queue between the IFU's spill-merge stage and the decode stage. It decouples fetch from decode stalls: each fetched, merged 32-bit instruction is written into a small FIFO, and decode reads one entry per cycle. The block is instantiated when the fetch buffer is enabled in the configuration; in that configuration spill-taking in the IFU is disabled and fetch stalls come from this block's full flag.

## Interface
Parameters:
- WIDTH, 32, bits per entry (instruction width).
- DEPTH, 3, number of entries; legal range 2–8; need not be a power of 2.

Ports (clock and reset first; reset is synchronous, active-high; clock is clk):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- FlushD  in  1  discard all contents (branch mispredict or trap).
- StallD  in  1  decode holds; no entry is consumed this cycle.
- InstrF  in  WIDTH  merged instruction from fetch.
- InstrValidF  in  1  InstrF is valid this cycle.
- FetchStallF  out  1  buffer full; IFU must hold PCF and re-present InstrF.
- InstrD  out  WIDTH  head entry, presented to decode.
- InstrValidD  out  1  InstrD holds a real instruction.
- CountF  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State:
  - head and tail pointers, each 0..DEPTH-1, wrapping DEPTH-1 → 0;
  - occupancy counter CountF, 0..DEPTH;
  - storage array of DEPTH×WIDTH registers.
- Push = InstrValidF & ~FetchStallF & ~FlushD. Push writes InstrF at tail and advances tail.
- Pop = InstrValidD & ~StallD & ~FlushD. Pop advances head.
- Push and pop in the same cycle: both pointers advance and CountF is unchanged.
- Full: FetchStallF = (CountF == DEPTH). FetchStallF depends only on registered state; it never combinationally depends on StallD.
- A push attempted while full is dropped. The IFU holds its PC, so the instruction is re-presented.
- Empty (CountF == 0): InstrValidD = 0 and InstrD = NOP (32'h0000_0013).
- Non-empty: InstrD = storage[head] and InstrValidD = 1.
- FlushD: on the next edge, head, tail and CountF go to 0. Any push or pop in the flush cycle is ignored.
- FlushD has priority over push and pop.
- Reset has priority over FlushD.
- Reset values:
  - CountF = 0, head = 0, tail = 0;
  - InstrValidD = 0, InstrD = NOP, FetchStallF = 0;
  - storage contents don't-care.

## Timing
- Write-to-read latency is 1 cycle without bypass. An instruction pushed at edge N is visible on InstrD after edge N.
- Throughput is one push and one pop per cycle in steady state when 0 < CountF < DEPTH.
- FetchStallF asserts the cycle after the push that fills the buffer. It deasserts the cycle after the first pop from a full buffer.
- Reset or flush asserted in the middle of a fill or drain sequence takes effect at the next edge. There is no partial state.

## Configuration
- Macro: FETCHBUF_BYPASS_EN.
- Defined: when CountF == 0, InstrValidF = 1 and FlushD = 0:
  - InstrD = InstrF and InstrValidD = 1 combinationally in the same cycle.
  - If StallD = 0, the instruction is consumed without being written, and CountF stays 0.
  - If StallD = 1, it is written normally.
- Undefined: no combinational path from InstrF to InstrD. Latency is always 1 cycle.

## Structure
- Shared package holds NOP_INSTR (32'h0000_0013). The package already carries the fetch-buffer enable and depth configuration fields.
- One sub-module, fetch_buffer_ptr:
  - modulo-DEPTH wrap counter with enable and synchronous clear;
  - instantiated twice, once for head and once for tail.
- Storage is a flop array (no SRAM) with a one-hot write decode from tail and a read mux from head.

## Test plan
- Reset, then idle → CountF = 0, InstrValidD = 0, InstrD = 32'h00000013, FetchStallF = 0.
- Push 32'h00A00093 with StallD = 0 (bypass off) → InstrD = 32'h00A00093 with InstrValidD = 1 one cycle later; CountF returns to 0 after the pop.
- StallD = 1 and push 4 instructions with DEPTH = 3 → first 3 stored; FetchStallF = 1 after the third; 4th dropped; CountF = 3. Release StallD → the 3 instructions pop in order, then the re-presented 4th is pushed.
- Continuous push/pop for 10 cycles → pointers wrap from 2 to 0 with no loss or reordering.
- FlushD asserted with CountF = 2 and a simultaneous push → next cycle CountF = 0 and InstrValidD = 0; the pushed word never appears.
- FETCHBUF_BYPASS_EN defined, empty buffer, push 32'h00000513 with StallD = 0 → same-cycle InstrD = 32'h00000513 and InstrValidD = 1; CountF stays 0.
